// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Purpose:
//   Next-PC predictor for an LC-3b fetch stage. Conditional branches (op_br)
//   use a direct-mapped, untagged table of 2-bit saturating counters indexed
//   by pc[INDEX_BITS:1]. Unconditional control flow (jsr, trap, jmp) is
//   always redirected. The execute stage trains the counters and receives a
//   registered one-cycle mispredict pulse for flush/redirect.
//
// Optional feature (macro BPU_PERF_CNT_EN):
//   When defined, perf_lookups counts cycles with a valid op_br fetch and
//   perf_mispredicts counts detected mispredictions, both saturating at
//   16'hFFFF. When undefined, both outputs are tied to zero and no counter
//   flops exist.
//
// Parameters:
//   INDEX_BITS  table index width, 2**INDEX_BITS entries (legal 1..8)
//   CNT_INIT    reset value of every 2-bit counter
//
// Ports:
//   clk              in   sole clock, rising edge
//   rst              in   synchronous active-high reset
//   fetch_valid      in   fetch stage presents an instruction
//   fetch_pc         in   16-bit PC of the fetched instruction
//   fetch_opcode     in   4-bit LC-3b opcode of the fetched instruction
//   pred_sel         out  next-PC select: 00 pc+2, 01 target, 10 trap, 11 jmp
//   pred_taken       out  fetch redirected away from pc+2
//   res_valid        in   execute stage resolves an instruction this cycle
//   res_pc           in   16-bit PC of the resolving instruction
//   res_is_br        in   resolving instruction is op_br
//   res_taken        in   actual branch outcome
//   res_pred_taken   in   prediction carried down the pipe with the branch
//   mispredict       out  registered one-cycle flush/redirect request
//   perf_lookups     out  16-bit op_br lookup count (see macro above)
//   perf_mispredicts out  16-bit mispredict count (see macro above)
//
// Handshake: there is no backpressure. fetch_valid and res_valid are
// qualifiers only; each asserted cycle is consumed in that same cycle.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned INDEX_BITS = 4,
    parameter logic [1:0]  CNT_INIT   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_pc,
    input  logic [3:0]  fetch_opcode,
    output logic [1:0]  pred_sel,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic        res_is_br,
    input  logic        res_taken,
    input  logic        res_pred_taken,
    output logic        mispredict,
    output logic [15:0] perf_lookups,
    output logic [15:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [1:0] SEL_PC2    = 2'b00;
    localparam logic [1:0] SEL_TARGET = 2'b01;
    localparam logic [1:0] SEL_TRAP   = 2'b10;
    localparam logic [1:0] SEL_JMP    = 2'b11;

    logic [1:0]            cnt_q [ENTRIES];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] res_idx;
    logic [1:0]            fetch_cnt;
    logic [1:0]            res_cnt;
    logic [1:0]            res_cnt_d;
    logic                  res_upd;
    logic                  mispredict_d;
    logic                  mispredict_q;

    // Bit 0 is always zero for word-aligned instructions; upper bits are
    // deliberately dropped so aliased PCs share a counter.
    assign fetch_idx = fetch_pc[INDEX_BITS:1];
    assign res_idx   = res_pc[INDEX_BITS:1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[15:INDEX_BITS+1], fetch_pc[0],
                              res_pc[15:INDEX_BITS+1], res_pc[0]};

    // Fetch reads the registered table, so a same-cycle update to the same
    // index is not visible until the next cycle.
    assign fetch_cnt = cnt_q[fetch_idx];
    assign res_cnt   = cnt_q[res_idx];

    always_comb begin
        pred_sel = SEL_PC2;
        if (fetch_valid) begin
            case (fetch_opcode)
                OP_BR:   pred_sel = fetch_cnt[1] ? SEL_TARGET : SEL_PC2;
                OP_JSR:  pred_sel = SEL_TARGET;
                OP_TRAP: pred_sel = SEL_TRAP;
                OP_JMP:  pred_sel = SEL_JMP;
                default: pred_sel = SEL_PC2;
            endcase
        end
    end

    assign pred_taken = (pred_sel != SEL_PC2);

    assign res_upd      = res_valid && res_is_br;
    assign mispredict_d = res_upd && (res_taken != res_pred_taken);

    // Saturating 2-bit counter step for the resolving entry.
    always_comb begin
        res_cnt_d = res_cnt;
        if (res_taken) begin
            if (res_cnt != 2'b11) res_cnt_d = res_cnt + 2'd1;
        end else begin
            if (res_cnt != 2'b00) res_cnt_d = res_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
            mispredict_q <= 1'b0;
        end else begin
            if (res_upd) begin
                cnt_q[res_idx] <= res_cnt_d;
            end
            mispredict_q <= mispredict_d;
        end
    end

    assign mispredict = mispredict_q;

`ifdef BPU_PERF_CNT_EN
    logic [15:0] perf_lookups_q;
    logic [15:0] perf_mispredicts_q;
    logic        lookup_hit;

    assign lookup_hit = fetch_valid && (fetch_opcode == OP_BR);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookups_q     <= 16'h0000;
            perf_mispredicts_q <= 16'h0000;
        end else begin
            if (lookup_hit && (perf_lookups_q != 16'hFFFF)) begin
                perf_lookups_q <= perf_lookups_q + 16'd1;
            end
            if (mispredict_d && (perf_mispredicts_q != 16'hFFFF)) begin
                perf_mispredicts_q <= perf_mispredicts_q + 16'd1;
            end
        end
    end

    assign perf_lookups     = perf_lookups_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    assign perf_lookups     = 16'h0000;
    assign perf_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Self-checking bench for branch_predict_unit (INDEX_BITS=4, CNT_INIT=01).
// A behavioural model (integer counter array, saturating arithmetic) tracks
// the predictor; a compare process checks every output at each negedge once
// the model has seen a reset edge. Directed sequences add literal checks,
// then a randomized phase exercises aliasing, back-to-back resolves and
// random resets. Honours BPU_PERF_CNT_EN for the performance outputs.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int         IB      = 4;
    localparam int         ENTRIES = 16;
    localparam logic [1:0] CINIT   = 2'b01;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic [3:0]  fetch_opcode;
    logic [1:0]  pred_sel;
    logic        pred_taken;
    logic        res_valid;
    logic [15:0] res_pc;
    logic        res_is_br;
    logic        res_taken;
    logic        res_pred_taken;
    logic        mispredict;
    logic [15:0] perf_lookups;
    logic [15:0] perf_mispredicts;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    branch_predict_unit #(
        .INDEX_BITS(IB),
        .CNT_INIT  (CINIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .fetch_opcode    (fetch_opcode),
        .pred_sel        (pred_sel),
        .pred_taken      (pred_taken),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_is_br       (res_is_br),
        .res_taken       (res_taken),
        .res_pred_taken  (res_pred_taken),
        .mispredict      (mispredict),
        .perf_lookups    (perf_lookups),
        .perf_mispredicts(perf_mispredicts)
    );

    // ---------------- scoreboard counters ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [ENTRIES];
    int m_mis;
    int m_look;
    int m_misc;
    bit model_ok = 1'b0;

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) / 2) % ENTRIES;
    endfunction

    function automatic int model_sel();
        if (!fetch_valid) return 0;
        case (int'(fetch_opcode))
            0:       return (m_cnt[idx_of(fetch_pc)] >= 2) ? 1 : 0;
            4:       return 1;
            15:      return 2;
            12:      return 3;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m_cnt[i] <= int'(CINIT);
            m_mis    <= 0;
            m_look   <= 0;
            m_misc   <= 0;
            model_ok <= 1'b1;
        end else begin
            if (res_valid && res_is_br) begin
                if (res_taken) m_cnt[idx_of(res_pc)] <= (m_cnt[idx_of(res_pc)] == 3) ? 3 : m_cnt[idx_of(res_pc)] + 1;
                else           m_cnt[idx_of(res_pc)] <= (m_cnt[idx_of(res_pc)] == 0) ? 0 : m_cnt[idx_of(res_pc)] - 1;
            end
            m_mis <= (res_valid && res_is_br && (res_taken != res_pred_taken)) ? 1 : 0;
            if (fetch_valid && fetch_opcode == 4'h0 && m_look < 65535) m_look <= m_look + 1;
            if (res_valid && res_is_br && (res_taken != res_pred_taken) && m_misc < 65535)
                m_misc <= m_misc + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            check("pred_sel", int'(pred_sel), model_sel());
            check("pred_taken", int'(pred_taken), (model_sel() != 0) ? 1 : 0);
            check("mispredict", int'(mispredict), m_mis);
`ifdef BPU_PERF_CNT_EN
            check("perf_lookups", int'(perf_lookups), m_look);
            check("perf_mispredicts", int'(perf_mispredicts), m_misc);
`else
            check("perf_lookups", int'(perf_lookups), 0);
            check("perf_mispredicts", int'(perf_mispredicts), 0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid = 0; fetch_pc = 16'h0; fetch_opcode = 4'h1;
        res_valid = 0; res_pc = 16'h0; res_is_br = 0; res_taken = 0; res_pred_taken = 0;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [3:0] op);
        fetch_valid = 1; fetch_pc = pc; fetch_opcode = op;
    endtask

    task automatic resolve(input logic [15:0] pc, input logic tk, input logic ptk);
        res_valid = 1; res_is_br = 1; res_pc = pc; res_taken = tk; res_pred_taken = ptk;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1;
        idle();
        cycle();
        cycle();
        rst = 0;

        // Reset state: counter 01 predicts not-taken.
        fetch(16'h0040, 4'h0); #1;
        check("rst_pred_sel", int'(pred_sel), 0);
        check("rst_pred_taken", int'(pred_taken), 0);

        // Two mispredicted taken resolves on index 0.
        resolve(16'h0040, 1, 0);
        cycle();
        check("mis_first", int'(mispredict), 1);
        cycle();
        check("mis_second", int'(mispredict), 1);
        res_valid = 0;
        fetch(16'h0040, 4'h0); #1;
        check("trained_sel", int'(pred_sel), 1);
        fetch(16'h0060, 4'h0); #1;
        check("alias_sel", int'(pred_sel), 1);
        cycle();
        check("mis_clear", int'(mispredict), 0);

        // Saturation: five taken then one not-taken on index 5 ends at 10.
        resolve(16'h000A, 1, 1);
        repeat (5) cycle();
        check("sat_no_mis", int'(mispredict), 0);
        resolve(16'h000A, 0, 1);
        cycle();
        check("sat_nt_mis", int'(mispredict), 1);
        res_valid = 0;
        fetch(16'h000A, 4'h0); #1;
        check("sat_sel", int'(pred_sel), 1);

        // Unconditional opcodes and fetch_valid=0.
        fetch(16'h0100, 4'hF); #1; check("trap_sel", int'(pred_sel), 2);
        fetch(16'h0100, 4'hC); #1; check("jmp_sel", int'(pred_sel), 3);
        fetch(16'h0100, 4'h4); #1; check("jsr_sel", int'(pred_sel), 1);
        fetch(16'h0100, 4'h1); #1; check("add_sel", int'(pred_sel), 0);
        check("add_taken", int'(pred_taken), 0);
        fetch(16'h0100, 4'hF); fetch_valid = 0; #1;
        check("novalid_sel", int'(pred_sel), 0);
        check("novalid_taken", int'(pred_taken), 0);

        // Same-cycle resolve and fetch on index 3: fetch sees pre-update value.
        fetch(16'h0006, 4'h0);
        resolve(16'h0006, 1, 0); #1;
        check("bypass_old", int'(pred_sel), 0);
        cycle();
        res_valid = 0; #1;
        check("bypass_new", int'(pred_sel), 1);

        // Reset with a mispredict pending drops it.
        resolve(16'h0006, 0, 1);
        cycle();
        check("pend_mis", int'(mispredict), 1);
        rst = 1;
        resolve(16'h0006, 0, 1);
        cycle();
        check("rst_mis_drop", int'(mispredict), 0);
        fetch(16'h0040, 4'h0); #1;
        check("rst_func_sel", int'(pred_sel), 0);
        rst = 0;
        idle();
        cycle();
        check("post_rst_mis", int'(mispredict), 0);
        fetch(16'h0006, 4'h0); #1; check("rst_cnt_idx3", int'(pred_sel), 0);
        fetch(16'h000A, 4'h0); #1; check("rst_cnt_idx5", int'(pred_sel), 0);

        // Performance counters: 3 br lookups and 1 mispredict after reset.
        rst = 1;
        idle();
        cycle();
        rst = 0;
        fetch(16'h0010, 4'h0);
        repeat (3) cycle();
        fetch_valid = 0;
        resolve(16'h0010, 1, 0);
        cycle();
        res_valid = 0;
`ifdef BPU_PERF_CNT_EN
        check("perf_look_3", int'(perf_lookups), 3);
        check("perf_mis_1", int'(perf_mispredicts), 1);
`else
        check("perf_look_0", int'(perf_lookups), 0);
        check("perf_mis_0", int'(perf_mispredicts), 0);
`endif

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            fetch_valid    = ($urandom_range(0, 3) != 0);
            fetch_pc       = 16'($urandom_range(0, 65535));
            fetch_opcode   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            res_valid      = ($urandom_range(0, 2) != 0);
            res_is_br      = ($urandom_range(0, 3) != 0);
            res_pc         = ($urandom_range(0, 1) == 0) ? fetch_pc : 16'($urandom_range(0, 65535));
            res_taken      = 1'($urandom_range(0, 1));
            res_pred_taken = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 0;
        idle();
        repeat (3) cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
